// File: rtl/hazard_fwd_scoreboard_if.sv
// Bundle of pipeline-control signals between the core datapath and the hazard/forwarding unit.
// The master modport drives the pipeline-stage fields, and the slave modport returns the selects, stall and long-unit status.
interface hazard_fwd_scoreboard_if #(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned CNT_W   = 32
);
  logic [NUM_SRC*REG_AW-1:0] id_src;
  logic [NUM_SRC-1:0]        id_src_used;
  logic                      id_is_branch;
  logic                      id_long_issue;
  logic [REG_AW-1:0]         id_rd;
  logic [NUM_SRC*REG_AW-1:0] ex_src;
  logic                      id_ex_regwrite;
  logic                      id_ex_memread;
  logic [REG_AW-1:0]         id_ex_rd;
  logic                      ex_mem_regwrite;
  logic                      ex_mem_memread;
  logic [REG_AW-1:0]         ex_mem_rd;
  logic                      mem_wb_regwrite;
  logic [REG_AW-1:0]         mem_wb_rd;

  logic [2*NUM_SRC-1:0]      ex_fwd_sel;
  logic [2*NUM_SRC-1:0]      id_cmp_sel;
  logic                      stall;
  logic [1:0]                stall_cause;
  logic                      long_busy;
  logic                      long_wb_valid;
  logic [REG_AW-1:0]         long_wb_rd;
  logic [CNT_W-1:0]          stall_cnt;

  modport master (
    output id_src, id_src_used, id_is_branch, id_long_issue, id_rd, ex_src,
           id_ex_regwrite, id_ex_memread, id_ex_rd,
           ex_mem_regwrite, ex_mem_memread, ex_mem_rd,
           mem_wb_regwrite, mem_wb_rd,
    input  ex_fwd_sel, id_cmp_sel, stall, stall_cause,
           long_busy, long_wb_valid, long_wb_rd, stall_cnt
  );

  modport slave (
    input  id_src, id_src_used, id_is_branch, id_long_issue, id_rd, ex_src,
           id_ex_regwrite, id_ex_memread, id_ex_rd,
           ex_mem_regwrite, ex_mem_memread, ex_mem_rd,
           mem_wb_regwrite, mem_wb_rd,
    output ex_fwd_sel, id_cmp_sel, stall, stall_cause,
           long_busy, long_wb_valid, long_wb_rd, stall_cnt
  );
endinterface

// File: rtl/hazard_fwd_scoreboard.sv
// Forwarding selects, RAW/structural hazard detection and stall generation for a 5-stage core,
// plus occupancy tracking of a single non-pipelined fixed-latency long unit.
module hazard_fwd_scoreboard #(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned NUM_SRC  = 2,
  parameter int unsigned LONG_LAT = 4,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  hazard_fwd_scoreboard_if.slave   bus
);

  localparam int unsigned LCW = $clog2(LONG_LAT + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [LCW-1:0]     cnt_q, cnt_d;
  logic [REG_AW-1:0]  lq_rd_q, lq_rd_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic [2*NUM_SRC-1:0] ex_fwd_sel_c;
  logic [2*NUM_SRC-1:0] id_cmp_sel_c;
  logic                 lu_haz_c;
  logic                 br_haz_c;
  logic                 raw_long_c;
  logic                 long_haz_c;
  logic                 stall_c;
  logic [1:0]           stall_cause_c;
  logic                 long_busy_c;
  logic                 long_wb_c;
  logic                 accept_c;

  function automatic logic [REG_AW-1:0] src_at(input logic [NUM_SRC*REG_AW-1:0] v,
                                               input int unsigned idx);
    return v[idx*REG_AW +: REG_AW];
  endfunction

  // Register 0 is hardwired zero, so a write to it can never be a forwarding source.
  function automatic logic rd_hit(input logic we, input logic [REG_AW-1:0] rd,
                                  input logic [REG_AW-1:0] src);
    return we && (rd != '0) && (rd == src);
  endfunction

  // Forwarding: the younger EX/MEM result wins over MEM/WB.
  always_comb begin
    ex_fwd_sel_c = '0;
    id_cmp_sel_c = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (rd_hit(bus.ex_mem_regwrite, bus.ex_mem_rd, src_at(bus.ex_src, i))) begin
        ex_fwd_sel_c[2*i +: 2] = 2'b10;
      end else if (rd_hit(bus.mem_wb_regwrite, bus.mem_wb_rd, src_at(bus.ex_src, i))) begin
        ex_fwd_sel_c[2*i +: 2] = 2'b01;
      end
      if (rd_hit(bus.ex_mem_regwrite, bus.ex_mem_rd, src_at(bus.id_src, i))) begin
        id_cmp_sel_c[2*i +: 2] = 2'b01;
      end else if (rd_hit(bus.mem_wb_regwrite, bus.mem_wb_rd, src_at(bus.id_src, i))) begin
        id_cmp_sel_c[2*i +: 2] = 2'b10;
      end
    end
  end

  // Per-source RAW checks; unused or x0 sources never create a hazard.
  always_comb begin
    lu_haz_c   = 1'b0;
    br_haz_c   = 1'b0;
    raw_long_c = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (bus.id_src_used[i] && (src_at(bus.id_src, i) != '0)) begin
        if (bus.id_ex_memread && (bus.id_ex_rd == src_at(bus.id_src, i))) begin
          lu_haz_c = 1'b1;
        end
        if (bus.id_is_branch &&
            ((bus.id_ex_regwrite && (bus.id_ex_rd == src_at(bus.id_src, i))) ||
             (bus.ex_mem_memread && (bus.ex_mem_rd == src_at(bus.id_src, i))))) begin
          br_haz_c = 1'b1;
        end
        if (lq_rd_q == src_at(bus.id_src, i)) begin
          raw_long_c = 1'b1;
        end
      end
    end
  end

  // Reset forces the unit to appear idle immediately, so an aborted op never shows busy or a writeback.
  assign long_busy_c = (state_q == S_BUSY) && !rst;

  assign long_haz_c = long_busy_c &&
                      (raw_long_c ||
                       ((bus.id_rd != '0) && (bus.id_rd == lq_rd_q)) ||
                       bus.id_long_issue);

  assign stall_c = long_haz_c || lu_haz_c || br_haz_c;

  always_comb begin
    stall_cause_c = 2'b00;
    if (long_haz_c) begin
      stall_cause_c = 2'b11;
    end else if (lu_haz_c) begin
      stall_cause_c = 2'b01;
    end else if (br_haz_c) begin
      stall_cause_c = 2'b10;
    end
  end

  assign accept_c = bus.id_long_issue && !stall_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      lq_rd_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lq_rd_q     <= lq_rd_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Long-unit occupancy: the writeback pulse comes in the last busy cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lq_rd_d   = lq_rd_q;
    long_wb_c = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          state_d = S_BUSY;
          cnt_d   = LCW'(LONG_LAT);
          lq_rd_d = bus.id_rd;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - LCW'(1);
        if (cnt_q == LCW'(1)) begin
          long_wb_c = !rst;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign stall_cnt_d = (stall_c && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;

  assign bus.ex_fwd_sel    = ex_fwd_sel_c;
  assign bus.id_cmp_sel    = id_cmp_sel_c;
  assign bus.stall         = stall_c;
  assign bus.stall_cause   = stall_cause_c;
  assign bus.long_busy     = long_busy_c;
  assign bus.long_wb_valid = long_wb_c;
  assign bus.long_wb_rd    = lq_rd_q;
  assign bus.stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_hazard_fwd_scoreboard.sv
// Directed bench for hazard_fwd_scoreboard: expected outputs are queued per cycle and compared
// at the falling edge; the stall counter expectation is a saturating tally of expected stalls.
module tb_hazard_fwd_scoreboard;

  localparam int unsigned REG_AW   = 5;
  localparam int unsigned NUM_SRC  = 2;
  localparam int unsigned LONG_LAT = 4;
  localparam int unsigned CNT_W    = 4;

  typedef struct packed {
    logic [3:0] fwd;
    logic [3:0] cmp;
    logic       stall;
    logic [1:0] cause;
    logic       busy;
    logic       wbv;
    logic [4:0] wbrd;
  } exp_t;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   exp_cnt;
  exp_t exp_q[$];

  hazard_fwd_scoreboard_if #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .CNT_W(CNT_W)) bus ();

  hazard_fwd_scoreboard #(
    .REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .LONG_LAT(LONG_LAT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input string what,
                     input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    rst                 = 1'b0;
    bus.id_src          = '0;
    bus.id_src_used     = '0;
    bus.id_is_branch    = 1'b0;
    bus.id_long_issue   = 1'b0;
    bus.id_rd           = '0;
    bus.ex_src          = '0;
    bus.id_ex_regwrite  = 1'b0;
    bus.id_ex_memread   = 1'b0;
    bus.id_ex_rd        = '0;
    bus.ex_mem_regwrite = 1'b0;
    bus.ex_mem_memread  = 1'b0;
    bus.ex_mem_rd       = '0;
    bus.mem_wb_regwrite = 1'b0;
    bus.mem_wb_rd       = '0;
  endtask

  // One pipeline cycle: queue the expectation, compare at negedge, advance past the next posedge.
  task automatic step(input string tag, input logic [3:0] fwd, input logic [3:0] cmp,
                      input logic st, input logic [1:0] cause, input logic busy,
                      input logic wbv, input logic [4:0] wbrd);
    exp_t e;
    e.fwd = fwd; e.cmp = cmp; e.stall = st; e.cause = cause;
    e.busy = busy; e.wbv = wbv; e.wbrd = wbrd;
    exp_q.push_back(e);
    @(negedge clk);
    e = exp_q.pop_front();
    chk(tag, "ex_fwd_sel",    32'(bus.ex_fwd_sel),    32'(e.fwd));
    chk(tag, "id_cmp_sel",    32'(bus.id_cmp_sel),    32'(e.cmp));
    chk(tag, "stall",         32'(bus.stall),         32'(e.stall));
    chk(tag, "stall_cause",   32'(bus.stall_cause),   32'(e.cause));
    chk(tag, "long_busy",     32'(bus.long_busy),     32'(e.busy));
    chk(tag, "long_wb_valid", 32'(bus.long_wb_valid), 32'(e.wbv));
    if (e.wbv) chk(tag, "long_wb_rd", 32'(bus.long_wb_rd), 32'(e.wbrd));
    chk(tag, "stall_cnt",     32'(bus.stall_cnt),     32'(exp_cnt));
    @(posedge clk);
    if (rst) exp_cnt = 0;
    else if (e.stall && exp_cnt != 15) exp_cnt++;
    #1;
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    exp_cnt = 0;
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    // Reset held: everything quiet, counter cleared.
    step("reset", 4'b0000, 4'b0000, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0);
    idle_inputs();
    step("idle", 4'b0000, 4'b0000, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0);

    // Forwarding priority and x0.
    bus.ex_mem_regwrite = 1'b1; bus.ex_mem_rd = 5'd5;
    bus.mem_wb_regwrite = 1'b1; bus.mem_wb_rd = 5'd5;
    bus.ex_src = {5'd0, 5'd5};
    step("fwd_exmem", 4'b0010, 4'b0000, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0);
    bus.ex_mem_rd = 5'd0;
    step("fwd_memwb", 4'b0001, 4'b0000, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0);
    bus.ex_mem_rd = 5'd6;
    bus.ex_src = {5'd5, 5'd5};
    bus.id_src = {5'd5, 5'd6};
    step("fwd_both", 4'b0101, 4'b1001, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0);
    bus.ex_mem_rd = 5'd0; bus.mem_wb_rd = 5'd0;
    bus.ex_src = '0; bus.id_src = '0;
    step("fwd_x0", 4'b0000, 4'b0000, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0);

    // Load-use.
    idle_inputs();
    bus.id_ex_memread = 1'b1; bus.id_ex_regwrite = 1'b1; bus.id_ex_rd = 5'd7;
    bus.id_src = {5'd7, 5'd0}; bus.id_src_used = 2'b10;
    step("lu_stall", 4'b0000, 4'b0000, 1'b1, 2'b01, 1'b0, 1'b0, 5'd0);
    bus.id_src_used = 2'b00;
    step("lu_unused", 4'b0000, 4'b0000, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0);
    bus.id_ex_rd = 5'd0; bus.id_src = '0; bus.id_src_used = 2'b11;
    step("lu_x0", 4'b0000, 4'b0000, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0);

    // Branch in ID.
    idle_inputs();
    bus.id_is_branch = 1'b1; bus.id_ex_regwrite = 1'b1; bus.id_ex_rd = 5'd3;
    bus.id_src = {5'd0, 5'd3}; bus.id_src_used = 2'b01;
    step("br_stall", 4'b0000, 4'b0000, 1'b1, 2'b10, 1'b0, 1'b0, 5'd0);
    bus.id_ex_regwrite = 1'b0; bus.id_ex_rd = 5'd0;
    bus.ex_mem_regwrite = 1'b1; bus.ex_mem_rd = 5'd3;
    step("br_fwd", 4'b0000, 4'b0001, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0);
    bus.ex_mem_memread = 1'b1;
    step("br_load", 4'b0000, 4'b0001, 1'b1, 2'b10, 1'b0, 1'b0, 5'd0);
    bus.ex_mem_memread = 1'b0; bus.ex_mem_regwrite = 1'b0; bus.ex_mem_rd = 5'd0;
    bus.id_ex_memread = 1'b1; bus.id_ex_regwrite = 1'b1; bus.id_ex_rd = 5'd3;
    step("lu_over_br", 4'b0000, 4'b0000, 1'b1, 2'b01, 1'b0, 1'b0, 5'd0);

    // Long op to x9 accepted at edge 0; reader of x9 waits four cycles.
    idle_inputs();
    bus.id_long_issue = 1'b1; bus.id_rd = 5'd9;
    step("long_issue", 4'b0000, 4'b0000, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0);
    idle_inputs();
    bus.id_src = {5'd0, 5'd9}; bus.id_src_used = 2'b01; bus.id_rd = 5'd10;
    step("long_c0", 4'b0000, 4'b0000, 1'b1, 2'b11, 1'b1, 1'b0, 5'd0);
    step("long_c1", 4'b0000, 4'b0000, 1'b1, 2'b11, 1'b1, 1'b0, 5'd0);
    step("long_c2", 4'b0000, 4'b0000, 1'b1, 2'b11, 1'b1, 1'b0, 5'd0);
    step("long_c3", 4'b0000, 4'b0000, 1'b1, 2'b11, 1'b1, 1'b1, 5'd9);
    step("long_c4", 4'b0000, 4'b0000, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0);

    // Structural hazard, WAW, then reset mid-op.
    idle_inputs();
    bus.id_long_issue = 1'b1; bus.id_rd = 5'd12;
    step("l2_issue", 4'b0000, 4'b0000, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0);
    bus.id_rd = 5'd13;
    step("l2_struct0", 4'b0000, 4'b0000, 1'b1, 2'b11, 1'b1, 1'b0, 5'd0);
    step("l2_struct1", 4'b0000, 4'b0000, 1'b1, 2'b11, 1'b1, 1'b0, 5'd0);
    step("l2_struct2", 4'b0000, 4'b0000, 1'b1, 2'b11, 1'b1, 1'b0, 5'd0);
    step("l2_struct3", 4'b0000, 4'b0000, 1'b1, 2'b11, 1'b1, 1'b1, 5'd12);
    step("l3_accept", 4'b0000, 4'b0000, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0);
    bus.id_long_issue = 1'b0;
    step("l3_waw", 4'b0000, 4'b0000, 1'b1, 2'b11, 1'b1, 1'b0, 5'd0);
    bus.id_rd = 5'd0;
    step("l3_free", 4'b0000, 4'b0000, 1'b0, 2'b00, 1'b1, 1'b0, 5'd0);
    rst = 1'b1;
    step("l3_rst", 4'b0000, 4'b0000, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0);
    rst = 1'b0;
    step("l3_no_wb", 4'b0000, 4'b0000, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0);

    // Long op to x0 still occupies the unit and pulses writeback.
    idle_inputs();
    bus.id_long_issue = 1'b1; bus.id_rd = 5'd0;
    step("l0_issue", 4'b0000, 4'b0000, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0);
    bus.id_long_issue = 1'b0;
    bus.id_src = {5'd0, 5'd0}; bus.id_src_used = 2'b11;
    step("l0_c0", 4'b0000, 4'b0000, 1'b0, 2'b00, 1'b1, 1'b0, 5'd0);
    step("l0_c1", 4'b0000, 4'b0000, 1'b0, 2'b00, 1'b1, 1'b0, 5'd0);
    step("l0_c2", 4'b0000, 4'b0000, 1'b0, 2'b00, 1'b1, 1'b0, 5'd0);
    step("l0_c3", 4'b0000, 4'b0000, 1'b0, 2'b00, 1'b1, 1'b1, 5'd0);
    step("l0_c4", 4'b0000, 4'b0000, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0);

    // Sustained stall saturates the 4-bit counter; reset clears it.
    idle_inputs();
    bus.id_ex_memread = 1'b1; bus.id_ex_regwrite = 1'b1; bus.id_ex_rd = 5'd7;
    bus.id_src = {5'd0, 5'd7}; bus.id_src_used = 2'b01;
    for (int k = 0; k < 20; k++) begin
      step("sat_hold", 4'b0000, 4'b0000, 1'b1, 2'b01, 1'b0, 1'b0, 5'd0);
    end
    chk("sat_final", "stall_cnt", 32'(bus.stall_cnt), 32'd15);
    rst = 1'b1;
    step("sat_rst", 4'b0000, 4'b0000, 1'b1, 2'b01, 1'b0, 1'b0, 5'd0);
    idle_inputs();
    chk("sat_cleared", "stall_cnt", 32'(bus.stall_cnt), 32'd0);
    step("after_rst", 4'b0000, 4'b0000, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
